// File: rtl/axi_region_router.sv
// Register-access router: decodes the top address bits into a target region, strobes it,
// and waits for that target's done (with timeout) on independent write and read channels.
module axi_region_router #(
    parameter int                 NUM_SLV   = 3,
    parameter int                 ADDR_W    = 32,
    parameter int                 DATA_W    = 32,
    parameter int                 SEL_W     = 2,
    parameter int                 LOCAL_AW  = 16,
    parameter logic [NUM_SLV-1:0] READ_MASK = 'b001,
    parameter int                 TIMEOUT   = 255,
    parameter logic [DATA_W-1:0]  ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we,
    input  logic [ADDR_W-1:0]         waddr,
    input  logic [DATA_W-1:0]         wdata,
    output logic                      wready,
    output logic                      wdone,
    output logic                      werr,
    input  logic                      re,
    input  logic [ADDR_W-1:0]         raddr,
    output logic                      rready,
    output logic                      rdone,
    output logic                      rerr,
    output logic [DATA_W-1:0]         rdata,
    output logic [NUM_SLV-1:0]        s_we,
    output logic [LOCAL_AW-1:0]       s_waddr,
    output logic [DATA_W-1:0]         s_wdata,
    input  logic [NUM_SLV-1:0]        s_wdone,
    output logic [NUM_SLV-1:0]        s_re,
    output logic [LOCAL_AW-1:0]       s_raddr,
    input  logic [NUM_SLV*DATA_W-1:0] s_rdata,
    input  logic [NUM_SLV-1:0]        s_rdone
);
    localparam int NT = 1 << SEL_W;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    // Region tables widened to the full select space so unpopulated regions decode as errors.
    logic [NT-1:0]             wr_ok, rd_ok, wdone_x, rdone_x;
    logic [NT-1:0][DATA_W-1:0] rd_arr;

    for (genvar i = 0; i < NT; i++) begin : g_map
        if (i < NUM_SLV) begin : g_on
            assign wr_ok[i]   = 1'b1;
            assign rd_ok[i]   = READ_MASK[i];
            assign wdone_x[i] = s_wdone[i];
            assign rdone_x[i] = s_rdone[i];
            assign rd_arr[i]  = s_rdata[i*DATA_W +: DATA_W];
        end else begin : g_off
            assign wr_ok[i]   = 1'b0;
            assign rd_ok[i]   = 1'b0;
            assign wdone_x[i] = 1'b0;
            assign rdone_x[i] = 1'b0;
            assign rd_arr[i]  = '0;
        end
    end

    logic unused_addr_bits;
    assign unused_addr_bits = ^{waddr, raddr};

    // ---------------- write channel ----------------
    state_t           w_state, w_next;
    logic [SEL_W-1:0] w_sel, w_idx;
    logic [NT-1:0]    w_oh;
    logic [CW-1:0]    w_cnt;
    logic             w_err, w_acc, w_hit, w_to;

    assign w_sel  = waddr[ADDR_W-1 -: SEL_W];
    assign w_oh   = NT'(1) << w_sel;
    assign w_acc  = we && (w_state == IDLE);
    assign w_hit  = (w_state == WAIT) && wdone_x[w_idx];
    assign w_to   = (TIMEOUT != 0) && (w_state == WAIT) && (w_cnt == CW'(TIMEOUT - 1));
    assign wready = (w_state == IDLE);
    assign wdone  = (w_state == RESP);
    assign werr   = wdone && w_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) w_state <= IDLE;
        else        w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            IDLE:    if (w_acc) w_next = wr_ok[w_sel] ? WAIT : RESP;
            WAIT:    if (w_hit || w_to) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_idx   <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
            s_we    <= '0;
            s_waddr <= '0;
            s_wdata <= '0;
        end else begin
            s_we <= '0;
            if (w_acc) begin
                w_idx   <= w_sel;
                s_waddr <= waddr[LOCAL_AW+1:2];
                s_wdata <= wdata;
                w_cnt   <= '0;
                w_err   <= !wr_ok[w_sel];
                if (wr_ok[w_sel]) s_we <= w_oh[NUM_SLV-1:0];
            end else if (w_state == WAIT) begin
                // A done in the timeout cycle still wins, so err follows the done bit alone.
                w_cnt <= w_cnt + 1'b1;
                w_err <= !w_hit;
            end
        end
    end

    // ---------------- read channel ----------------
    state_t           r_state, r_next;
    logic [SEL_W-1:0] r_sel, r_idx;
    logic [NT-1:0]    r_oh;
    logic [CW-1:0]    r_cnt;
    logic             r_err, r_acc, r_hit, r_to;

    assign r_sel  = raddr[ADDR_W-1 -: SEL_W];
    assign r_oh   = NT'(1) << r_sel;
    assign r_acc  = re && (r_state == IDLE);
    assign r_hit  = (r_state == WAIT) && rdone_x[r_idx];
    assign r_to   = (TIMEOUT != 0) && (r_state == WAIT) && (r_cnt == CW'(TIMEOUT - 1));
    assign rready = (r_state == IDLE);
    assign rdone  = (r_state == RESP);
    assign rerr   = rdone && r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            IDLE:    if (r_acc) r_next = rd_ok[r_sel] ? WAIT : RESP;
            WAIT:    if (r_hit || r_to) r_next = RESP;
            RESP:    r_next = IDLE;
            default: r_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            s_re    <= '0;
            s_raddr <= '0;
            rdata   <= '0;
        end else begin
            s_re <= '0;
            if (r_acc) begin
                r_idx   <= r_sel;
                s_raddr <= raddr[LOCAL_AW+1:2];
                r_cnt   <= '0;
                r_err   <= !rd_ok[r_sel];
                if (rd_ok[r_sel]) s_re  <= r_oh[NUM_SLV-1:0];
                else              rdata <= ERR_DATA;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt + 1'b1;
                r_err <= !r_hit;
                if (r_hit)     rdata <= rd_arr[r_idx];
                else if (r_to) rdata <= ERR_DATA;
            end
        end
    end

endmodule
